// File: rtl/seg_spin_decoder.sv
// Receive-side monitor for the spinning seven-segment driver: measures per-segment duty,
// picks the brightest segment as the head and tracks spin position, direction and step period.
module seg_spin_decoder #(
    parameter int WINDOW_WIDTH = 6,
    parameter int MIN_LEVEL    = 4,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic                    invert,
    output logic [27:0]             seg_level,
    output logic [2:0]              position,
    output logic                    direction,
    output logic                    locked,
    output logic                    step_valid,
    output logic                    step_error,
    output logic [PERIOD_WIDTH-1:0] step_period
);

    localparam int CW    = WINDOW_WIDTH + 1;
    localparam int SHIFT = WINDOW_WIDTH - 4;

    typedef enum logic {StSearch, StLocked} state_t;

    logic [6:0]              seg_s1, seg_s2;
    logic                    inv_s1, inv_s2;
    logic [6:0]              sample;
    logic [WINDOW_WIDTH-1:0] win_cnt;
    logic                    win_end;
    logic                    head_due;
    logic [CW-1:0]           high_cnt [7];
    logic [3:0]              level [7];
    logic [PERIOD_WIDTH-1:0] period_cnt;
    state_t                  state;

    logic [3:0] head_lvl;
    logic [2:0] head_seg;
    logic       head_ok;
    logic       head_same;
    logic [2:0] cand_a, cand_b, pos_fwd, pos_bwd;

    function automatic logic [3:0] scale(input logic [CW-1:0] sum);
        logic [CW-1:0] s;
        s = sum >> SHIFT;
        return (s > CW'(15)) ? 4'd15 : s[3:0];
    endfunction

    function automatic logic [2:0] seg_to_pos(input logic [2:0] seg);
        case (seg)
            3'd0:    return 3'd0;
            3'd1:    return 3'd1;
            3'd2:    return 3'd5;
            3'd3:    return 3'd4;
            3'd4:    return 3'd3;
            3'd5:    return 3'd7;
            default: return 3'd2;
        endcase
    endfunction

    function automatic logic [2:0] pos_to_seg(input logic [2:0] pos);
        case (pos)
            3'd0:    return 3'd0;
            3'd1:    return 3'd1;
            3'd2:    return 3'd6;
            3'd3:    return 3'd4;
            3'd4:    return 3'd3;
            3'd5:    return 3'd2;
            3'd6:    return 3'd6;
            default: return 3'd5;
        endcase
    endfunction

    assign sample  = seg_s2 ^ {7{inv_s2}};
    assign win_end = &win_cnt;
    assign locked  = (state == StLocked);

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            seg_level[4*i +: 4] = level[i];
        end
    end

    // Lowest index wins ties because only a strictly greater level replaces the head.
    always_comb begin
        head_lvl = level[0];
        head_seg = 3'd0;
        for (int i = 1; i < 7; i++) begin
            if (level[i] > head_lvl) begin
                head_lvl = level[i];
                head_seg = 3'(i);
            end
        end
    end

    assign head_ok   = {28'd0, head_lvl} >= 32'(MIN_LEVEL);
    assign head_same = (head_seg == pos_to_seg(position));
    assign cand_a    = seg_to_pos(head_seg);
    assign cand_b    = (head_seg == 3'd6) ? 3'd6 : cand_a;
    assign pos_fwd   = position + 3'd1;
    assign pos_bwd   = position - 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            inv_s1   <= 1'b0;
            inv_s2   <= 1'b0;
            win_cnt  <= '0;
            head_due <= 1'b0;
            for (int i = 0; i < 7; i++) begin
                high_cnt[i] <= '0;
                level[i]    <= '0;
            end
        end else begin
            seg_s1   <= seg_in;
            seg_s2   <= seg_s1;
            inv_s1   <= invert;
            inv_s2   <= inv_s1;
            win_cnt  <= win_cnt + 1'b1;
            head_due <= win_end;
            for (int i = 0; i < 7; i++) begin
                if (win_end) begin
                    // Include the window's final sample so a full-on line measures 2^W.
                    level[i]    <= scale(high_cnt[i] + CW'(sample[i]));
                    high_cnt[i] <= '0;
                end else begin
                    high_cnt[i] <= high_cnt[i] + CW'(sample[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StSearch;
            position    <= '0;
            direction   <= 1'b0;
            step_valid  <= 1'b0;
            step_error  <= 1'b0;
            step_period <= '0;
            period_cnt  <= '0;
        end else begin
            step_valid <= 1'b0;
            step_error <= 1'b0;
            period_cnt <= (&period_cnt) ? period_cnt : period_cnt + 1'b1;
            if (head_due) begin
                if (!head_ok) begin
                    state <= StSearch;
                end else if (state == StSearch) begin
                    state      <= StLocked;
                    position   <= cand_a;
                    period_cnt <= '0;
                end else if (!head_same) begin
                    if (cand_a == pos_fwd || cand_b == pos_fwd) begin
                        position    <= pos_fwd;
                        direction   <= 1'b1;
                        step_valid  <= 1'b1;
                        step_period <= period_cnt;
                    end else if (cand_a == pos_bwd || cand_b == pos_bwd) begin
                        position    <= pos_bwd;
                        direction   <= 1'b0;
                        step_valid  <= 1'b1;
                        step_period <= period_cnt;
                    end else begin
                        position   <= cand_a;
                        step_error <= 1'b1;
                    end
                    period_cnt <= '0;
                end
            end
        end
    end

endmodule
